fb_scan_reader: RTL and testbench

FB_SCAN_READER -- requirements
Module: fb_scan_reader

---
 rtl/fb_scan_reader_if.sv | 27 ++
 rtl/fb_scan_reader.sv | 93 +++++++++
 tb/tb_fb_scan_reader.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fb_scan_reader_if.sv
// Handshake bundle between the framebuffer scan reader, its framebuffer read port
// and the downstream pixel consumer.
interface fb_scan_reader_if #(
  parameter int DW = 8,
  parameter int AW = 10
);
  logic          frame_start;
  logic [AW-1:0] ram_adr;
  logic [DW-1:0] ram_dat_r;
  logic          out_vld;
  logic          out_rdy;
  logic [DW-1:0] out_dat;
  logic          out_eol;
  logic          out_eof;
  logic          busy;
  logic          fs_miss;

  modport master (
    input  frame_start, ram_dat_r, out_rdy,
    output ram_adr, out_vld, out_dat, out_eol, out_eof, busy, fs_miss
  );

  modport slave (
    output frame_start, ram_dat_r, out_rdy,
    input  ram_adr, out_vld, out_dat, out_eol, out_eof, busy, fs_miss
  );
endinterface

// File: rtl/fb_scan_reader.sv
// Scans a framebuffer in address order through a registered-read port and streams
// the words out over a valid/ready link with line and frame tags.
module fb_scan_reader #(
  parameter int DW = 8,
  parameter int MD = 1024,
  parameter int LW = 32,
  parameter int AW = $clog2(MD)
) (
  input logic             clk,
  input logic             rst_n,
  fb_scan_reader_if.master bus
);
  localparam int CW = (LW > 1) ? $clog2(LW) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  typedef struct packed {
    logic [DW-1:0] dat;
    logic          eol;
    logic          eof;
  } word_t;

  state_t        state;
  logic [AW-1:0] cnt, adr_q;
  logic [CW-1:0] col;
  logic [1:0]    occ, occ_nxt, wp;
  logic          infl, infl_eol, infl_eof;
  logic          pop, issue, last_adr;
  word_t         buf0, buf1, wr;

  assign pop      = (occ != 2'd0) && bus.out_rdy;
  assign wp       = occ - {1'b0, pop};
  assign occ_nxt  = wp + {1'b0, infl};
  // Credit counts the word landing this cycle so the 2-entry buffer never overflows.
  assign issue    = (state == RUN) && (occ_nxt < 2'd2);
  assign last_adr = (cnt == AW'(MD-1));
  assign wr       = '{dat: bus.ram_dat_r, eol: infl_eol, eof: infl_eof};

  // Address only advances on an issue; otherwise it parks on the last one sent.
  assign bus.ram_adr = issue ? cnt : adr_q;
  assign bus.out_vld = (occ != 2'd0);
  assign bus.out_dat = buf0.dat;
  assign bus.out_eol = buf0.eol;
  assign bus.out_eof = buf0.eof;
  assign bus.busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      adr_q       <= '0;
      col         <= '0;
      occ         <= '0;
      infl        <= 1'b0;
      infl_eol    <= 1'b0;
      infl_eof    <= 1'b0;
      buf0        <= '0;
      buf1        <= '0;
      bus.fs_miss <= 1'b0;
    end else begin
      bus.fs_miss <= bus.frame_start && (state != IDLE);
      occ         <= occ_nxt;
      infl        <= issue;
      if (issue) begin
        infl_eol <= (col == CW'(LW-1));
        infl_eof <= last_adr;
        adr_q    <= cnt;
      end
      if (pop) buf0 <= buf1;
      if (infl) begin
        if (wp == 2'd0) buf0 <= wr;
        else            buf1 <= wr;
      end
      case (state)
        IDLE: if (bus.frame_start) begin
          state <= RUN;
          cnt   <= '0;
          col   <= '0;
        end
        RUN: if (issue) begin
          if (last_adr) state <= DRAIN;
          else          cnt   <= cnt + 1'b1;
          col <= (col == CW'(LW-1)) ? '0 : col + 1'b1;
        end
        DRAIN: if (occ_nxt == 2'd0) begin
          state <= IDLE;
          cnt   <= '0;
          adr_q <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_scan_reader.sv
// Directed bench for fb_scan_reader: a frame-level model predicts the word stream,
// busy and fs_miss, and one negedge process compares every cycle.
module tb_fb_scan_reader;
  localparam int DW = 8, MD = 16, LW = 4, AW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fb_scan_reader_if #(.DW(DW), .AW(AW)) bus();
  fb_scan_reader #(.DW(DW), .MD(MD), .LW(LW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  logic [DW-1:0] mem [MD];
  initial for (int i = 0; i < MD; i++) mem[i] = DW'(i);
  always @(posedge clk) bus.ram_dat_r <= mem[bus.ram_adr];

  int total = 0, bad = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // frame-level model state
  int   exp_a[$];
  bit   m_busy = 0, fs_exp = 0, pv_stall = 0, pv_busy = 0, first_pend = 0;
  logic [DW+1:0] pv_word;
  int   cyc = 0, acc_cyc = -100, max_adr = -1, xfer = 0;
  int   first_vld_off = 0, first_xfer_cyc = 0, eof_cyc = 0, fall_cyc = 0, fs_cnt = 0;
  int   lg[$];
  logic [15:0] eol_mask = '0;
  int   n_eof = 0;

  always @(negedge clk) begin
    bit nb;
    int a;
    cyc++;
    if (!rst_n) begin
      chk("rst_outputs_zero", {bus.out_vld, bus.out_eol, bus.out_eof, bus.busy,
                               bus.fs_miss, bus.ram_adr, bus.out_dat}, 0);
      m_busy = 0; fs_exp = 0; pv_stall = 0; pv_busy = 0; first_pend = 0;
      exp_a.delete(); acc_cyc = -100;
    end else begin
      chk("busy", bus.busy, m_busy);
      chk("fs_miss", bus.fs_miss, fs_exp);
      if (bus.fs_miss) fs_cnt++;
      if (pv_busy && !bus.busy) fall_cyc = cyc;
      if (cyc == acc_cyc + 1) chk("first_adr_zero", bus.ram_adr, 0);
      if (first_pend && bus.out_vld) begin
        first_pend = 0;
        first_vld_off = cyc - acc_cyc;
        chk("first_vld_latency", first_vld_off, 3);
      end
      if (!m_busy) chk("idle_no_vld", bus.out_vld, 0);
      if (pv_stall) begin
        chk("stall_vld_held", bus.out_vld, 1);
        chk("stall_word_stable", {bus.out_dat, bus.out_eol, bus.out_eof}, pv_word);
      end
      if (m_busy) begin
        chk("adr_ascending", (int'(bus.ram_adr) == max_adr) || (int'(bus.ram_adr) == max_adr + 1), 1);
        if (int'(bus.ram_adr) > max_adr) max_adr = int'(bus.ram_adr);
      end
      nb = m_busy;
      if (bus.out_vld && bus.out_rdy) begin
        if (exp_a.size() == 0) chk("unexpected_word", exp_a.size(), 1);
        else begin
          a = exp_a.pop_front();
          chk("out_dat", bus.out_dat, a);
          chk("out_eol", bus.out_eol, (a % LW) == LW - 1);
          chk("out_eof", bus.out_eof, a == MD - 1);
          lg.push_back(int'(bus.out_dat));
          if (bus.out_eol) eol_mask[bus.out_dat[3:0]] = 1'b1;
          xfer++;
          if (a == 0) first_xfer_cyc = cyc;
          if (a == MD - 1) begin eof_cyc = cyc; n_eof++; nb = 0; end
        end
      end
      if (m_busy) chk("outstanding_le2", (max_adr + 1 - xfer) <= 2, 1);
      fs_exp = bus.frame_start && m_busy;
      if (bus.frame_start && !m_busy) begin
        nb = 1;
        for (int i = 0; i < MD; i++) exp_a.push_back(i);
        acc_cyc = cyc; first_pend = 1; max_adr = -1; xfer = 0;
      end
      pv_stall = bus.out_vld && !bus.out_rdy;
      pv_word  = {bus.out_dat, bus.out_eol, bus.out_eof};
      pv_busy  = bus.busy;
      m_busy   = nb;
    end
  end

  logic [31:0] pat = 32'b1001_1100_0110_1011_0011_1001_0100_1101;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse();
    bus.frame_start = 1'b1; step(); bus.frame_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input bit pat_mode);
    int n = 0;
    while (m_busy && n < 300) begin
      if (pat_mode) begin bus.out_rdy = pat[0]; pat = {pat[0], pat[31:1]}; end
      step(); n++;
    end
    chk({nm, "_timeout"}, n < 300, 1);
    bus.out_rdy = 1'b1;
  endtask

  task automatic clr_log();
    lg.delete(); eol_mask = '0; n_eof = 0; fs_cnt = 0;
  endtask

  initial begin
    int n;
    bus.frame_start = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // free-running frame
    clr_log(); pulse(); wait_idle("t1", 0);
    chk("t1_count", lg.size(), 16);
    chk("t1_eol_mask", eol_mask, 16'h8888);
    chk("t1_eof_count", n_eof, 1);
    chk("t1_first_vld", first_vld_off, 3);
    chk("t1_span", eof_cyc - first_xfer_cyc, 15);
    step();
    chk("t1_busy_fall", fall_cyc - eof_cyc, 1);

    // pseudo-random back-pressure
    clr_log(); pulse(); wait_idle("t2", 1);
    chk("t2_count", lg.size(), 16);
    chk("t2_last", lg[lg.size()-1], 15);

    // stalled from the start
    clr_log(); bus.out_rdy = 1'b0; pulse();
    repeat (8) step();
    chk("t3_max_adr", max_adr, 1);
    chk("t3_ram_adr", bus.ram_adr, 1);
    chk("t3_vld", bus.out_vld, 1);
    chk("t3_dat", bus.out_dat, 0);
    bus.out_rdy = 1'b1;
    wait_idle("t3", 0);
    chk("t3_count", lg.size(), 16);

    // frame_start while busy
    clr_log(); pulse();
    n = 0;
    while (lg.size() < 6 && n < 100) begin step(); n++; end
    pulse();
    wait_idle("t4", 0);
    repeat (5) step();
    chk("t4_fs_miss_pulses", fs_cnt, 1);
    chk("t4_count", lg.size(), 16);
    chk("t4_no_second_frame", bus.busy, 0);

    // reset mid-frame
    clr_log(); pulse();
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.out_vld && bus.out_dat == 8'd9) && n < 100);
    chk("t5_reach_word9", n < 100, 1);
    #1 rst_n = 1'b0;
    #1 chk("t5_async_zero", {bus.out_vld, bus.out_eol, bus.out_eof, bus.busy,
                             bus.fs_miss, bus.ram_adr, bus.out_dat}, 0);
    step(); step();
    rst_n = 1'b1;
    clr_log();
    repeat (8) step();
    chk("t5_idle_vld", bus.out_vld, 0);
    chk("t5_idle_words", lg.size(), 0);
    pulse(); wait_idle("t5", 0);
    chk("t5_count", lg.size(), 16);
    chk("t5_restart_first", lg[0], 0);

    // back-to-back frames
    clr_log(); pulse();
    n = 0;
    while (n_eof == 0 && n < 100) begin step(); n++; end
    pulse();
    wait_idle("t6", 0);
    chk("t6_count", lg.size(), 32);
    chk("t6_second_first", lg[16], 0);
    chk("t6_second_last", lg[31], 15);
    chk("t6_no_miss", fs_cnt, 0);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
